// File: rtl/serial_sub_borrow.sv
// serial_sub_borrow
// Bit-serial subtractor that computes Diff = A - B - Bin, modulo 2^WIDTH, and the final borrow.
// A single full-subtractor cell handles one bit per clock, least significant bit first.
// Operands are captured on a valid/ready handshake. The result and the borrow are registered
// and change only when an operation completes.

module serial_sub_borrow #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             busy,
   output logic             done
);

   // The counter only needs to reach WIDTH-1. WIDTH is at least 2, so CNT_W is at least 1.
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e            state_q;
   logic [WIDTH-1:0]  a_q;        // minuend; its LSB is the bit being processed
   logic [WIDTH-1:0]  b_q;        // subtrahend; its LSB is the bit being processed
   logic [WIDTH-1:0]  res_q;      // partial difference, filled from the MSB side
   logic [CNT_W-1:0]  cnt_q;      // index of the bit being processed
   logic              br_q;       // borrow into the current bit
   logic [WIDTH-1:0]  diff_q;
   logic              bout_q;
   logic              busy_q;
   logic              done_q;
   logic              ready_q;

   logic              accept;
   logic              diff_bit;
   logic              br_d;
   logic [WIDTH-1:0]  res_d;

   // A request is taken only in IDLE. A reset in the same cycle overrides it.
   assign accept = start_valid && ready_q;

   // Full-subtractor cell for the current bit, plus the next value of the result shift register.
   always_comb begin
      // NOTE: give every always_comb output a default first, so no path can infer a latch.
      diff_bit = 1'b0;
      br_d     = 1'b0;
      res_d    = res_q;
      diff_bit = a_q[0] ^ b_q[0] ^ br_q;
      br_d     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      // Each new bit enters at the MSB. After WIDTH shifts, the first bit sits at bit 0.
      res_d    = {diff_bit, res_q[WIDTH-1:1]};
   end

   // Control FSM and datapath. Every output is driven directly from a register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only. Every register reads the
      // pre-edge value of the others, whatever order the statements are written in.
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  a_q     <= A;
                  b_q     <= B;
                  br_q    <= Bin;
                  res_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
                  state_q <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               br_q  <= br_d;
               res_q <= res_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BIT) begin
                  // The partial result is published only here, so Diff never shows it.
                  diff_q  <= res_d;
                  bout_q  <= br_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end

            S_DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign start_ready = ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign Diff        = diff_q;
   assign Bout        = bout_q;

endmodule

// File: tb/tb_serial_sub_borrow.sv
// tb_serial_sub_borrow
// Self-checking bench for serial_sub_borrow with WIDTH = 4.
// Expected results come from plain integer arithmetic on the operands.

module tb_serial_sub_borrow;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start_valid;
   logic         start_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Bin;
   logic [W-1:0] Diff;
   logic         Bout;
   logic         busy;
   logic         done;

   int n_checks = 0;
   int n_errors = 0;

   serial_sub_borrow #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .A           (A),
      .B           (B),
      .Bin         (Bin),
      .Diff        (Diff),
      .Bout        (Bout),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Outputs are sampled and inputs driven 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: {borrow, diff}, where borrow = (A < B + Bin) and diff = (A - B - Bin) mod 2^W.
   function automatic logic [W:0] ref_sub(input int a, input int b, input int bin);
      int d;
      logic [W:0] r;
      d = a - b - bin;
      r[W-1:0] = W'(d & ((1 << W) - 1));
      r[W]     = (a < b + bin);
      return r;
   endfunction

   // Run one operation and check latency, the result, and that the held outputs stay stable
   // while the operand inputs toggle randomly.
   task automatic do_op(input int a, input int b, input int bin);
      logic [W:0]   exp;
      logic [W-1:0] held_diff;
      logic         held_bout;
      int           lat;
      for (int i = 0; i < 20 && !start_ready; i++) tick();
      check("ready_before_op", 32'(start_ready), 32'd1);
      held_diff   = Diff;
      held_bout   = Bout;
      A           = W'(a);
      B           = W'(b);
      Bin         = 1'(bin);
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      exp = ref_sub(a, b, bin);
      lat = 1;
      while (!done && lat < 20) begin
         check("busy_in_shift", 32'(busy), 32'd1);
         check("ready_in_shift", 32'(start_ready), 32'd0);
         check("diff_hold", 32'({Bout, Diff}), 32'({held_bout, held_diff}));
         A   = W'($urandom);
         B   = W'($urandom);
         Bin = 1'($urandom);
         tick();
         lat++;
      end
      check("done_seen", 32'(done), 32'd1);
      check("latency", 32'(lat), 32'd5);
      check("diff", 32'(Diff), 32'(exp[W-1:0]));
      check("bout", 32'(Bout), 32'(exp[W]));
      check("busy_in_done", 32'(busy), 32'd0);
      check("ready_in_done", 32'(start_ready), 32'd0);
      held_diff = Diff;
      held_bout = Bout;
      tick();
      check("done_one_cycle", 32'(done), 32'd0);
      check("ready_after_done", 32'(start_ready), 32'd1);
      check("diff_hold_idle", 32'({Bout, Diff}), 32'({held_bout, held_diff}));
   endtask

   initial begin
      logic [W:0] exp;
      int         done_cnt;

      rst         = 1'b1;
      start_valid = 1'b0;
      A           = '0;
      B           = '0;
      Bin         = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_ready", 32'(start_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_diff", 32'(Diff), 32'd0);
      check("rst_bout", 32'(Bout), 32'd0);

      // Directed cases, including the boundary patterns
      do_op(9, 3, 0);
      do_op(3, 9, 0);
      do_op(0, 0, 1);
      do_op(15, 15, 0);
      do_op(7, 7, 1);
      do_op(0, 15, 1);

      // start_valid held high through SHIFT and DONE with new operands
      A           = W'(9);
      B           = W'(3);
      Bin         = 1'b0;
      start_valid = 1'b1;
      tick();                          // accepted; cycle t+1
      A   = W'(3);
      B   = W'(9);
      Bin = 1'b1;
      repeat (4) tick();               // cycle t+5
      check("hold_done1", 32'(done), 32'd1);
      check("hold_diff1", 32'(Diff), 32'd6);
      check("hold_bout1", 32'(Bout), 32'd0);
      tick();                          // cycle t+6: IDLE, accepts the second op
      check("hold_ready_t6", 32'(start_ready), 32'd1);
      tick();                          // cycle t+7
      start_valid = 1'b0;
      check("hold_busy_t7", 32'(busy), 32'd1);
      repeat (3) tick();               // cycle t+10
      check("hold_no_done_t10", 32'(done), 32'd0);
      tick();                          // cycle t+11
      exp = ref_sub(3, 9, 1);
      check("hold_done2", 32'(done), 32'd1);
      check("hold_diff2", 32'(Diff), 32'(exp[W-1:0]));
      check("hold_bout2", 32'(Bout), 32'(exp[W]));
      tick();

      // Reset asserted in the second SHIFT cycle aborts the operation
      A           = W'(2);
      B           = W'(5);
      Bin         = 1'b0;
      start_valid = 1'b1;
      tick();                          // first SHIFT cycle
      start_valid = 1'b0;
      tick();                          // second SHIFT cycle
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_ready", 32'(start_ready), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_diff", 32'(Diff), 32'd0);
      check("abort_bout", 32'(Bout), 32'd0);
      done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) done_cnt++;
         tick();
      end
      check("abort_no_done", 32'(done_cnt), 32'd0);

      // Reset and start_valid in the same cycle: reset wins
      do_op(13, 2, 0);
      rst         = 1'b1;
      start_valid = 1'b1;
      A           = W'(5);
      B           = W'(1);
      tick();
      rst         = 1'b0;
      start_valid = 1'b0;
      check("rst_vs_start_busy", 32'(busy), 32'd0);
      check("rst_vs_start_ready", 32'(start_ready), 32'd1);
      check("rst_vs_start_diff", 32'(Diff), 32'd0);
      tick();
      check("rst_vs_start_still_idle", 32'(busy), 32'd0);

      // Exhaustive sweep over all 512 (A, B, Bin) combinations
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
               do_op(a, b, c);

      // Random operations
      for (int i = 0; i < 488; i++)
         do_op(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
